writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width.
REQ-002 Parameter REG_AW, default 4, register address width (16 registers).
REQ-003 The block SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 The block SHALL have port valid_in, input, 1, memory-stage outputs valid this cycle.
REQ-006 The block SHALL have port mem_out, input, DATA_W, load data from memory stage.
REQ-007 The block SHALL have port result_alu, input, DATA_W, ALU result passed through memory stage.
REQ-008 The block SHALL have port dir_wb, input, REG_AW, destination register.
REQ-009 The block SHALL have port sel_wb, input, 1, 1 = write mem_out, 0 = write result_alu.
REQ-010 The block SHALL have port reg_wr, input, 1, instruction writes a register.
REQ-011 The block SHALL have port stall, input, 1, freeze stage latch, suppress commit.
REQ-012 The block SHALL have port flush, input, 1, squash incoming instruction.
REQ-013 The block SHALL have ports rd_addr_a and rd_addr_b, input, REG_AW each, read addresses.
REQ-014 The block SHALL have ports rd_data_a and rd_data_b, output, DATA_W each, read data.
REQ-015 The block SHALL have ports fwd_valid (output, 1), fwd_dir (output, REG_AW) and fwd_data (output, DATA_W), pending-write forward to execute stage.
REQ-016 The block SHALL have port commit_cnt, output, 16, count of committed register writes.

Function
REQ-017 Stage latch SHALL capture {valid_in & reg_wr, dir_wb, selected data} on a rising edge when stall=0; selected data = sel_wb ? mem_out : result_alu.
REQ-018 With stall=1 the latch SHALL hold its contents unchanged.
REQ-019 With flush=1 the latch valid bit SHALL clear on the next edge regardless of stall; flush has priority over stall.
REQ-020 Register file write SHALL occur on an edge when latch valid=1 and stall=0: reg[latch dir] <= latch data. Latency from input to architectural state is 2 edges.
REQ-021 While stalled, a pending write SHALL NOT commit; it SHALL commit exactly once, on the first edge with stall=0.
REQ-022 All 16 registers SHALL be writable, including register 0.
REQ-023 Reads SHALL be combinational; if latch valid=1 and rd_addr equals latch dir, rd_data SHALL return latch data (bypass), else the register file value.
REQ-024 fwd_valid SHALL equal latch valid; fwd_dir and fwd_data SHALL equal latch contents.
REQ-025 commit_cnt SHALL increment by 1 per committed write, wrapping 0xFFFF -> 0x0000.
REQ-026 Simultaneous commit and new capture to the same dir SHALL leave the newer value pending in the latch, older value in the register file.

Reset
REQ-027 On rst_n=0, asynchronously: latch valid=0, latch dir=0, latch data=0, all registers=0, commit_cnt=0.
REQ-028 During reset, fwd_valid=0 and rd_data_a/b=0 for any address.
REQ-029 Reset asserted with a pending write SHALL discard that write.

Structure
REQ-030 DATA_W, REG_AW and register count SHALL live in the shared processor package.
REQ-031 Register file (16x DATA_W, one write port, two read ports) SHALL be one sub-module, reg_file; latch, select, bypass and counter SHALL be in writeback_stage.

Verification
REQ-032 Load path: valid_in=1, reg_wr=1, sel_wb=1, mem_out=0xDEADBEEF, dir_wb=3 -> fwd_valid=1 after edge 1; reg 3 = 0xDEADBEEF after edge 2; commit_cnt=1.
REQ-033 Bypass: pending write 0x12345678 to reg 5, rd_addr_a=5 same cycle -> rd_data_a=0x12345678 before commit.
REQ-034 Stall: pending write to reg 7, stall=1 for 3 cycles -> reg 7 unchanged, commit_cnt unchanged; stall=0 -> single commit, commit_cnt +1.
REQ-035 Flush+stall: flush=1, stall=1 with valid input to reg 2 -> fwd_valid=0 next cycle, reg 2 never written.
REQ-036 Back-to-back same dir: ALU writes 0x1 then 0x2 to reg 4 on consecutive cycles -> rd_data_b(4)=0x2 after second capture; reg 4 ends 0x2.
REQ-037 Async reset mid-write: rst_n low between edges with pending write -> outputs zero immediately; no commit after release.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// rtl/writeback_stage_pkg.sv - shared processor widths and writeback select encoding
package writeback_stage_pkg;

   localparam int DATA_W   = 32;
   localparam int REG_AW   = 4;
   localparam int NUM_REGS = 1 << REG_AW;
   localparam int CNT_W    = 16;

   typedef enum logic {
      SEL_ALU = 1'b0,
      SEL_MEM = 1'b1
   } wb_sel_e;

endpackage

// File: rtl/writeback_stage_reg_file.sv
// rtl/writeback_stage_reg_file.sv - architectural register file, one write port, two combinational read ports
module reg_file #(
   parameter int DATA_W = writeback_stage_pkg::DATA_W,
   parameter int REG_AW = writeback_stage_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [REG_AW-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [REG_AW-1:0] raddr_a_i,
   input  logic [REG_AW-1:0] raddr_b_i,
   output logic [DATA_W-1:0] rdata_a_o,
   output logic [DATA_W-1:0] rdata_b_o
);

   localparam int N_REGS = 1 << REG_AW;

   logic [DATA_W-1:0] regs_q [N_REGS];

   // Register 0 is an ordinary register here, not hardwired to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = regs_q[raddr_a_i];
   assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - writeback latch, result select, read bypass, forward port and commit counter
module writeback_stage #(
   parameter int DATA_W = writeback_stage_pkg::DATA_W,
   parameter int REG_AW = writeback_stage_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] mem_out,
   input  logic [DATA_W-1:0] result_alu,
   input  logic [REG_AW-1:0] dir_wb,
   input  logic              sel_wb,
   input  logic              reg_wr,
   input  logic              stall,
   input  logic              flush,
   input  logic [REG_AW-1:0] rd_addr_a,
   input  logic [REG_AW-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              fwd_valid,
   output logic [REG_AW-1:0] fwd_dir,
   output logic [DATA_W-1:0] fwd_data,
   output logic [15:0]       commit_cnt
);

   import writeback_stage_pkg::*;

   logic              lat_valid_q, lat_valid_d;
   logic [REG_AW-1:0] lat_dir_q,   lat_dir_d;
   logic [DATA_W-1:0] lat_data_q,  lat_data_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;
   logic [DATA_W-1:0] sel_data;
   logic              commit;
   logic [DATA_W-1:0] rf_data_a, rf_data_b;

   assign sel_data = (wb_sel_e'(sel_wb) == SEL_MEM) ? mem_out : result_alu;
   assign commit   = lat_valid_q & ~stall;

   always_comb begin
      lat_valid_d = lat_valid_q;
      lat_dir_d   = lat_dir_q;
      lat_data_d  = lat_data_q;
      cnt_d       = cnt_q;
      if (!stall) begin
         lat_valid_d = valid_in & reg_wr;
         lat_dir_d   = dir_wb;
         lat_data_d  = sel_data;
      end
      // A flush drops the latched instruction even while the pipe is frozen.
      if (flush) begin
         lat_valid_d = 1'b0;
      end
      if (commit) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_valid_q <= 1'b0;
         lat_dir_q   <= '0;
         lat_data_q  <= '0;
         cnt_q       <= '0;
      end else begin
         lat_valid_q <= lat_valid_d;
         lat_dir_q   <= lat_dir_d;
         lat_data_q  <= lat_data_d;
         cnt_q       <= cnt_d;
      end
   end

   reg_file #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_reg_file (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (commit),
      .waddr_i   (lat_dir_q),
      .wdata_i   (lat_data_q),
      .raddr_a_i (rd_addr_a),
      .raddr_b_i (rd_addr_b),
      .rdata_a_o (rf_data_a),
      .rdata_b_o (rf_data_b)
   );

   // The pending write is newer than the register file, so it wins on a match.
   assign rd_data_a = (lat_valid_q && (rd_addr_a == lat_dir_q)) ? lat_data_q : rf_data_a;
   assign rd_data_b = (lat_valid_q && (rd_addr_b == lat_dir_q)) ? lat_data_q : rf_data_b;

   assign fwd_valid  = lat_valid_q;
   assign fwd_dir    = lat_dir_q;
   assign fwd_data   = lat_data_q;
   assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - randomized self-checking bench for writeback_stage
module tb_writeback_stage;

   logic        clk;
   logic        rst_n;
   logic        valid_in;
   logic [31:0] mem_out;
   logic [31:0] result_alu;
   logic [3:0]  dir_wb;
   logic        sel_wb;
   logic        reg_wr;
   logic        stall;
   logic        flush;
   logic [3:0]  rd_addr_a;
   logic [3:0]  rd_addr_b;
   logic [31:0] rd_data_a;
   logic [31:0] rd_data_b;
   logic        fwd_valid;
   logic [3:0]  fwd_dir;
   logic [31:0] fwd_data;
   logic [15:0] commit_cnt;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   writeback_stage #(.DATA_W(32), .REG_AW(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_in   (valid_in),
      .mem_out    (mem_out),
      .result_alu (result_alu),
      .dir_wb     (dir_wb),
      .sel_wb     (sel_wb),
      .reg_wr     (reg_wr),
      .stall      (stall),
      .flush      (flush),
      .rd_addr_a  (rd_addr_a),
      .rd_addr_b  (rd_addr_b),
      .rd_data_a  (rd_data_a),
      .rd_data_b  (rd_data_b),
      .fwd_valid  (fwd_valid),
      .fwd_dir    (fwd_dir),
      .fwd_data   (fwd_data),
      .commit_cnt (commit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: one pending write slot, an array of registers, a commit count.
   logic        m_valid;
   logic [3:0]  m_dir;
   logic [31:0] m_data;
   logic [31:0] m_regs [16];
   logic [15:0] m_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_dir   <= 4'd0;
         m_data  <= 32'd0;
         m_cnt   <= 16'd0;
         for (int i = 0; i < 16; i++) m_regs[i] <= 32'd0;
      end else begin
         if (m_valid && !stall) begin
            m_regs[m_dir] <= m_data;
            m_cnt         <= m_cnt + 16'd1;
         end
         if (!stall) begin
            m_dir  <= dir_wb;
            m_data <= sel_wb ? mem_out : result_alu;
         end
         m_valid <= flush ? 1'b0 : (stall ? m_valid : (valid_in && reg_wr));
      end
   end

   function automatic logic [31:0] model_read(input logic [3:0] addr);
      if (m_valid && addr == m_dir) return m_data;
      return m_regs[addr];
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         if (!rst_n) begin
            check("rst_fwd_valid", 32'(fwd_valid), 32'd0);
            check("rst_rd_data_a", rd_data_a, 32'd0);
            check("rst_rd_data_b", rd_data_b, 32'd0);
            check("rst_commit_cnt", 32'(commit_cnt), 32'd0);
         end else begin
            check("fwd_valid", 32'(fwd_valid), 32'(m_valid));
            check("fwd_dir", 32'(fwd_dir), 32'(m_dir));
            check("fwd_data", fwd_data, m_data);
            check("rd_data_a", rd_data_a, model_read(rd_addr_a));
            check("rd_data_b", rd_data_b, model_read(rd_addr_b));
            check("commit_cnt", 32'(commit_cnt), 32'(m_cnt));
         end
      end
   end

   task automatic idle();
      valid_in   = 1'b0;
      reg_wr     = 1'b0;
      sel_wb     = 1'b0;
      mem_out    = 32'd0;
      result_alu = 32'd0;
      dir_wb     = 4'd0;
      stall      = 1'b0;
      flush      = 1'b0;
   endtask

   task automatic put(input logic sel, input logic [31:0] d, input logic [3:0] dir);
      valid_in   = 1'b1;
      reg_wr     = 1'b1;
      sel_wb     = sel;
      mem_out    = sel ? d : $urandom;
      result_alu = sel ? $urandom : d;
      dir_wb     = dir;
      stall      = 1'b0;
      flush      = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n     = 1'b1;
      rd_addr_a = 4'd0;
      rd_addr_b = 4'd0;
      idle();
      #1 rst_n = 1'b0;
      #1;
      check("init_fwd_valid", 32'(fwd_valid), 32'd0);
      check("init_rd_data_a", rd_data_a, 32'd0);
      check("init_commit_cnt", 32'(commit_cnt), 32'd0);
      chk_en = 1'b1;
      step();
      step();
      rst_n = 1'b1;
      step();

      // Load path to reg 3
      put(1'b1, 32'hDEADBEEF, 4'd3);
      step();
      idle();
      rd_addr_a = 4'd3;
      #1;
      check("load_fwd_valid", 32'(fwd_valid), 32'd1);
      check("load_fwd_dir", 32'(fwd_dir), 32'd3);
      check("load_fwd_data", fwd_data, 32'hDEADBEEF);
      step();
      check("load_reg3", rd_data_a, 32'hDEADBEEF);
      check("load_cnt", 32'(commit_cnt), 32'd1);

      // Bypass before commit
      put(1'b0, 32'h12345678, 4'd5);
      step();
      idle();
      rd_addr_a = 4'd5;
      #1;
      check("byp_rd_data_a", rd_data_a, 32'h12345678);
      check("byp_cnt_before", 32'(commit_cnt), 32'd1);
      step();
      check("byp_cnt_after", 32'(commit_cnt), 32'd2);

      // Stall holds a pending write to reg 7
      put(1'b0, 32'hA5A50007, 4'd7);
      step();
      idle();
      stall = 1'b1;
      rd_addr_b = 4'd7;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_cnt", 32'(commit_cnt), 32'd2);
         check("stall_fwd_valid", 32'(fwd_valid), 32'd1);
      end
      stall = 1'b0;
      step();
      check("unstall_cnt", 32'(commit_cnt), 32'd3);
      check("unstall_reg7", rd_data_b, 32'hA5A50007);
      step();
      check("unstall_once", 32'(commit_cnt), 32'd3);

      // Flush beats stall
      put(1'b0, 32'h00000022, 4'd2);
      flush = 1'b1;
      stall = 1'b1;
      step();
      idle();
      rd_addr_a = 4'd2;
      #1;
      check("flush_fwd_valid", 32'(fwd_valid), 32'd0);
      step();
      check("flush_reg2", rd_data_a, 32'd0);
      check("flush_cnt", 32'(commit_cnt), 32'd3);

      // Back-to-back writes to reg 4
      put(1'b0, 32'h1, 4'd4);
      step();
      put(1'b0, 32'h2, 4'd4);
      step();
      idle();
      rd_addr_b = 4'd4;
      #1;
      check("b2b_rd_data_b", rd_data_b, 32'h2);
      check("b2b_cnt", 32'(commit_cnt), 32'd4);
      step();
      check("b2b_reg4", rd_data_b, 32'h2);
      check("b2b_cnt_end", 32'(commit_cnt), 32'd5);

      // Asynchronous reset with a pending write
      put(1'b0, 32'h99, 4'd9);
      step();
      idle();
      rd_addr_a = 4'd9;
      #1 rst_n = 1'b0;
      #1;
      check("arst_fwd_valid", 32'(fwd_valid), 32'd0);
      check("arst_rd_data_a", rd_data_a, 32'd0);
      check("arst_rd_data_b", rd_data_b, 32'd0);
      check("arst_cnt", 32'(commit_cnt), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      check("arst_no_commit", rd_data_a, 32'd0);
      check("arst_cnt_after", 32'(commit_cnt), 32'd0);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         valid_in   = ($urandom_range(0, 3) != 0);
         reg_wr     = ($urandom_range(0, 4) != 0);
         sel_wb     = 1'($urandom);
         mem_out    = $urandom;
         result_alu = $urandom;
         dir_wb     = ($urandom_range(0, 3) == 0) ? fwd_dir : 4'($urandom);
         stall      = ($urandom_range(0, 3) == 0);
         flush      = ($urandom_range(0, 9) == 0);
         rd_addr_a  = ($urandom_range(0, 2) == 0) ? fwd_dir : 4'($urandom);
         rd_addr_b  = 4'($urandom);
         if ($urandom_range(0, 299) == 0) begin
            #1 rst_n = 1'b0;
            step();
            rst_n = 1'b1;
         end
         step();
      end

      idle();
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
